// File: rtl/uart_defs.sv
// Shared serial-link definitions: receiver/transmitter state encodings,
// default oversampling ratio, frame widths and the majority-vote helper.
package uart_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_W7        = 7;
    localparam int unsigned DATA_W8        = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive-line front end: 2-FF synchronizer, per-bit tick counter and
// 3-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_defs::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rtg_tick,
    input  logic rxd,
    input  logic cnt_clr,
    output logic rxd_sync,
    output logic bit_val,
    output logic bit_done,
    output logic bit_end
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned M  = OVERSAMPLE / 2;

    logic          sync1_r;
    logic          sync2_r;
    logic [TW-1:0] tcnt_r;
    logic          samp_a_r;
    logic          samp_b_r;

    // metastability synchronizer, idles high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
        end
    end

    // tick position within the current bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_r <= '0;
        end else if (cnt_clr) begin
            tcnt_r <= '0;
        end else if (rtg_tick) begin
            if (tcnt_r == TW'(OVERSAMPLE - 1)) begin
                tcnt_r <= '0;
            end else begin
                tcnt_r <= tcnt_r + TW'(1);
            end
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    // first two vote samples; the third is the live synchronized value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_a_r <= 1'b1;
            samp_b_r <= 1'b1;
        end else if (rtg_tick && (tcnt_r == TW'(M - 1))) begin
            samp_a_r <= sync2_r;
        end else if (rtg_tick && (tcnt_r == TW'(M))) begin
            samp_b_r <= sync2_r;
        end else begin
            samp_a_r <= samp_a_r;
            samp_b_r <= samp_b_r;
        end
    end

    assign rxd_sync = sync2_r;
    assign bit_val  = maj3(samp_a_r, samp_b_r, sync2_r);
    assign bit_done = rtg_tick && !cnt_clr && (tcnt_r == TW'(M + 1));
    assign bit_end  = rtg_tick && !cnt_clr && (tcnt_r == TW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_sized.sv
// UART receiver for 8N1/7N1 frames with a one-byte holding register,
// valid/ack handshake, glitch rejection, framing-error and overrun reporting.
module uart_rx_sized
    import uart_defs::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rtg_tick,
    input  logic       run_flag,
    input  logic       size_flag,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    uart_state_e state_r;
    uart_state_e state_nxt_s;

    logic       rxd_sync_s;
    logic       bit_val_s;
    logic       bit_done_s;
    logic       bit_end_s;
    logic       cnt_clr_s;
    logic       shift_en_s;
    logic       commit_s;
    logic       ferr_s;
    logic [7:0] shift_r;
    logic [3:0] bcnt_r;
    logic       wide_r;
    logic [3:0] frame_len_s;
    logic [7:0] frame_byte_s;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       frame_err_r;
    logic       overrun_r;

    // the tick counter is parked at zero while idle or disabled
    assign cnt_clr_s    = (state_r == ST_IDLE) || !run_flag;
    assign frame_len_s  = wide_r ? 4'(DATA_W8) : 4'(DATA_W7);
    assign frame_byte_s = wide_r ? shift_r : {1'b0, shift_r[7:1]};

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .rtg_tick (rtg_tick),
        .rxd      (rxd),
        .cnt_clr  (cnt_clr_s),
        .rxd_sync (rxd_sync_s),
        .bit_val  (bit_val_s),
        .bit_done (bit_done_s),
        .bit_end  (bit_end_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next state and per-cycle frame strobes
    always_comb begin
        state_nxt_s = state_r;
        shift_en_s  = 1'b0;
        commit_s    = 1'b0;
        ferr_s      = 1'b0;
        if (!run_flag) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rtg_tick && !rxd_sync_s) begin
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bit_done_s && bit_val_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (bit_end_s) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end
                ST_DATA: begin
                    shift_en_s = bit_done_s;
                    if (bit_end_s && (bcnt_r == frame_len_s)) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    // leave at the vote, not the bit end, so a following start edge is caught
                    if (bit_done_s) begin
                        state_nxt_s = ST_IDLE;
                        commit_s    = bit_val_s;
                        ferr_s      = !bit_val_s;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // frame assembly: width latched at start detect, bits enter at the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r <= 8'h00;
            bcnt_r  <= 4'd0;
            wide_r  <= 1'b1;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_START)) begin
            bcnt_r <= 4'd0;
            wide_r <= size_flag;
        end else if (shift_en_s) begin
            shift_r <= {bit_val_s, shift_r[7:1]};
            bcnt_r  <= bcnt_r + 4'd1;
        end else begin
            shift_r <= shift_r;
            bcnt_r  <= bcnt_r;
        end
    end

    // holding register, handshake and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= ferr_s;
            if (commit_s) begin
                if (!rx_valid_r) begin
                    rx_data_r  <= frame_byte_s;
                    rx_valid_r <= 1'b1;
                end else if (rx_ack) begin
                    rx_data_r  <= frame_byte_s;
                    rx_valid_r <= 1'b1;
                    overrun_r  <= 1'b0;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (rx_ack && rx_valid_r) begin
                rx_valid_r <= 1'b0;
                overrun_r  <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
                overrun_r  <= overrun_r;
            end
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_sized.sv
// Directed self-checking bench for uart_rx_sized: serial frames are driven
// tick-aligned on rxd and the holding-register outputs compared to fixed values.
module tb_uart_rx_sized;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rtg_tick;
    logic       run_flag;
    logic       size_flag;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_sized #(
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rtg_tick  (rtg_tick),
        .run_flag  (run_flag),
        .size_flag (size_flag),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // one-clock tick every 4 clocks
    initial begin
        rtg_tick = 1'b0;
        forever begin
            @(negedge clk);
            rtg_tick = 1'b1;
            @(negedge clk);
            rtg_tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    end

    // number of clocks frame_err has been high
    always @(negedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // returns on the negedge right after a clock edge that carried a tick
    task automatic next_tick();
        do @(posedge clk); while (rtg_tick !== 1'b1);
        @(negedge clk);
    endtask

    task automatic hold_ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // the stop vote lands on the 11th tick of the stop bit; ack_at_commit hits that edge
    task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop_val,
                              input bit ack_at_commit, input bit flip_size);
        next_tick();
        rxd = 1'b0;
        hold_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            rxd = data[i];
            if (flip_size && (i == 3)) size_flag = ~size_flag;
            hold_ticks(16);
        end
        rxd = stop_val;
        if (ack_at_commit) begin
            hold_ticks(10);
            repeat (3) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            hold_ticks(5);
        end else begin
            hold_ticks(16);
        end
        rxd = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        run_flag  = 1'b1;
        size_flag = 1'b1;
        rxd       = 1'b1;
        rx_ack    = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_data",  32'(rx_data),   32'h00);
        check_eq("rst_valid", 32'(rx_valid),  32'h0);
        check_eq("rst_ferr",  32'(frame_err), 32'h0);
        check_eq("rst_ovr",   32'(overrun),   32'h0);
        rst_n = 1'b1;
        hold_ticks(4);

        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0);
        check_eq("a5_data",  32'(rx_data),  32'hA5);
        check_eq("a5_valid", 32'(rx_valid), 32'h1);
        check_eq("a5_ferr",  32'(ferr_cnt), 32'd0);
        check_eq("a5_ovr",   32'(overrun),  32'h0);
        pulse_ack();
        check_eq("a5_ack_valid", 32'(rx_valid), 32'h0);

        size_flag = 1'b0;
        send_frame(8'h5A, 7, 1'b1, 1'b0, 1'b1);
        check_eq("w7_data",  32'(rx_data),    32'h5A);
        check_eq("w7_bit7",  32'(rx_data[7]), 32'h0);
        check_eq("w7_valid", 32'(rx_valid),   32'h1);
        pulse_ack();
        size_flag = 1'b1;

        next_tick();
        rxd = 1'b0;
        hold_ticks(3);
        rxd = 1'b1;
        hold_ticks(40);
        check_eq("glitch_valid", 32'(rx_valid), 32'h0);
        check_eq("glitch_ferr",  32'(ferr_cnt), 32'd0);
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0);
        check_eq("3c_data",  32'(rx_data),  32'h3C);
        check_eq("3c_valid", 32'(rx_valid), 32'h1);
        pulse_ack();

        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
        hold_ticks(30);
        check_eq("ferr_pulse", 32'(ferr_cnt), 32'd1);
        check_eq("ferr_valid", 32'(rx_valid), 32'h0);
        check_eq("ferr_data",  32'(rx_data),  32'h3C);

        send_frame(8'h11, 8, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 8, 1'b1, 1'b0, 1'b0);
        check_eq("b2b_data",  32'(rx_data),  32'h11);
        check_eq("b2b_valid", 32'(rx_valid), 32'h1);
        check_eq("b2b_ovr",   32'(overrun),  32'h1);
        pulse_ack();
        check_eq("b2b_ack_valid", 32'(rx_valid), 32'h0);
        check_eq("b2b_ack_ovr",   32'(overrun),  32'h0);

        send_frame(8'h11, 8, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 8, 1'b1, 1'b1, 1'b0);
        check_eq("ackc_data",  32'(rx_data),  32'h22);
        check_eq("ackc_valid", 32'(rx_valid), 32'h1);
        check_eq("ackc_ovr",   32'(overrun),  32'h0);
        pulse_ack();

        next_tick();
        rxd = 1'b0;
        hold_ticks(16 + 48);
        run_flag = 1'b0;
        rxd      = 1'b1;
        repeat (3) @(negedge clk);
        run_flag = 1'b1;
        hold_ticks(120);
        check_eq("run_valid", 32'(rx_valid), 32'h0);
        check_eq("run_ovr",   32'(overrun),  32'h0);
        check_eq("run_ferr",  32'(ferr_cnt), 32'd1);
        send_frame(8'h96, 8, 1'b1, 1'b0, 1'b0);
        check_eq("run_next_data",  32'(rx_data),  32'h96);
        check_eq("run_next_valid", 32'(rx_valid), 32'h1);

        send_frame(8'h44, 8, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_ovr",  32'(overrun), 32'h1);
        check_eq("pre_rst_data", 32'(rx_data), 32'h96);
        next_tick();
        rxd = 1'b0;
        hold_ticks(30);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_data",  32'(rx_data),   32'h00);
        check_eq("mid_rst_valid", 32'(rx_valid),  32'h0);
        check_eq("mid_rst_ferr",  32'(frame_err), 32'h0);
        check_eq("mid_rst_ovr",   32'(overrun),   32'h0);
        rst_n = 1'b1;
        rxd   = 1'b1;
        hold_ticks(40);
        check_eq("post_rst_valid", 32'(rx_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
